// File: rtl/bsnc_pkg.sv
// Shared types and width helpers for the bit-serial MAC and its input_buffer users.
package bsnc_pkg;

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DONE} mac_state_t;

  function automatic int acc_width(input int data_w, input int n_in);
    return 2 * data_w + $clog2(n_in);
  endfunction

endpackage

// File: rtl/bit_serial_mac_bit_plane_adder.sv
// Sums the weights of every lane whose input bit is set in the current bit-plane,
// using a balanced binary adder tree padded to a power-of-two lane count.
module bit_plane_adder #(
  parameter int DATA_W = 16,
  parameter int N_IN   = 128,
  parameter int PSUM_W = DATA_W + $clog2(N_IN)
) (
  input  logic [N_IN-1:0]        plane_i,
  input  logic [N_IN*DATA_W-1:0] weights_i,
  output logic [PSUM_W-1:0]      psum_o
);

  localparam int LEVELS = $clog2(N_IN);
  localparam int P      = 1 << LEVELS;

  genvar l, k;
  for (l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int CNT = P >> l;
    logic signed [PSUM_W-1:0] sum [CNT];
    for (k = 0; k < CNT; k++) begin : g_node
      if (l == 0) begin : g_leaf
        // Padding lanes beyond N_IN contribute zero so the tree stays balanced.
        if (k < N_IN) begin : g_real
          assign sum[k] = plane_i[k]
            ? PSUM_W'($signed(weights_i[(k+1)*DATA_W-1 -: DATA_W]))
            : '0;
        end else begin : g_pad
          assign sum[k] = '0;
        end
      end else begin : g_add
        assign sum[k] = g_lvl[l-1].sum[2*k] + g_lvl[l-1].sum[2*k+1];
      end
    end
  end

  assign psum_o = g_lvl[LEVELS].sum[0];

endmodule

// File: rtl/bit_serial_mac.sv
// Bit-serial signed dot product: one input bit-plane per cycle across all lanes,
// result presented on a valid/ready port with busy fed back to input_buffer.
module bit_serial_mac
  import bsnc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int N_IN   = 128,
  parameter int ACC_W  = acc_width(DATA_W, N_IN)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_IN*DATA_W-1:0] invec_bus,
  input  logic                   vector_done,
  input  logic [N_IN*DATA_W-1:0] wvec_bus,
  output logic                   busy,
  output logic [ACC_W-1:0]       result,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic                   protocol_err
);

  localparam int PSUM_W = DATA_W + $clog2(N_IN);
  localparam int CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  mac_state_t                state_q, state_d;
  logic [CNT_W-1:0]          bit_cnt_q, bit_cnt_d;
  logic [N_IN*DATA_W-1:0]    x_q, x_d;
  logic [N_IN*DATA_W-1:0]    w_q, w_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]          result_q, result_d;
  logic                      valid_q, valid_d;
  logic                      perr_q, perr_d;

  logic [N_IN-1:0]           plane;
  logic [PSUM_W-1:0]         psum;
  logic signed [ACC_W-1:0]   psum_ext;
  logic signed [ACC_W-1:0]   addend;

  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      plane[i] = x_q[i*DATA_W + int'(bit_cnt_q)];
    end
  end

  bit_plane_adder #(
    .DATA_W (DATA_W),
    .N_IN   (N_IN),
    .PSUM_W (PSUM_W)
  ) u_adder (
    .plane_i   (plane),
    .weights_i (w_q),
    .psum_o    (psum)
  );

  assign psum_ext = ACC_W'($signed(psum));
  assign addend   = psum_ext <<< bit_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      x_q       <= '0;
      w_q       <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      x_q       <= x_d;
      w_q       <= w_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    x_d       = x_q;
    w_d       = w_q;
    acc_d     = acc_q;
    result_d  = result_q;
    valid_d   = valid_q;
    perr_d    = perr_q;

    if (vector_done && state_q != S_IDLE) begin
      perr_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (vector_done) begin
          x_d       = invec_bus;
          w_d       = wvec_bus;
          acc_d     = '0;
          bit_cnt_d = '0;
          state_d   = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        // The top bit-plane carries negative weight in two's complement.
        if (bit_cnt_q == LAST_BIT) begin
          acc_d    = acc_q - addend;
          result_d = acc_d;
          valid_d  = 1'b1;
          state_d  = S_DONE;
        end else begin
          acc_d     = acc_q + addend;
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (result_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy         = vector_done | (state_q != S_IDLE);
  assign result       = result_q;
  assign result_valid = valid_q;
  assign protocol_err = perr_q;

endmodule
